// File: rtl/led_pattern_gen_if.sv
// Configuration handshake bundle for led_pattern_gen: valid/ready offer of mode and tick divisor.
interface led_pattern_gen_if #(
   parameter int PRESC_W = 24
);
   logic               cfg_valid;
   logic               cfg_ready;
   logic [1:0]         cfg_mode;
   logic [PRESC_W-1:0] cfg_div;

   modport master (output cfg_valid, output cfg_mode, output cfg_div, input cfg_ready);
   modport slave  (input cfg_valid, input cfg_mode, input cfg_div, output cfg_ready);
endinterface

// File: rtl/led_pattern_gen.sv
// LED pattern generator: prescaled OFF/BLINK/COUNT/CHASE patterns gated by a free-running PWM.
// Define LED_PATTERN_OUT_REG_EN to register LED and tick (+1 clk latency).
module led_pattern_gen #(
   parameter int LED_W   = 8,
   parameter int PRESC_W = 24,
   parameter int PWM_W   = 8
) (
   input  logic              clk,
   input  logic              rst_n,
   led_pattern_gen_if.slave  cfg,
   input  logic [PWM_W-1:0]  bright,
   output logic              tick,
   output logic [1:0]        mode,
   output logic [LED_W-1:0]  LED
);

   typedef enum logic [1:0] {
      MODE_OFF   = 2'd0,
      MODE_BLINK = 2'd1,
      MODE_COUNT = 2'd2,
      MODE_CHASE = 2'd3
   } mode_e;

   mode_e              mode_q, mode_d;
   mode_e              pend_mode_q, pend_mode_d;
   logic               pend_q, pend_d;
   logic [PRESC_W-1:0] div_q, div_d;
   logic [PRESC_W-1:0] pend_div_q, pend_div_d;
   logic [PRESC_W-1:0] presc_q, presc_d;
   logic [LED_W-1:0]   pat_q, pat_d;
   logic [PWM_W-1:0]   pwm_q;

   logic               tick_raw;
   logic               accept;
   logic               apply;
   logic               pwm_on;
   logic [LED_W-1:0]   led_raw;

   function automatic logic [LED_W-1:0] init_pat(input mode_e m);
      return (m == MODE_CHASE) ? LED_W'(1) : '0;
   endfunction

   assign tick_raw      = (presc_q == div_q);
   assign cfg.cfg_ready = ~pend_q;
   assign accept        = cfg.cfg_valid & ~pend_q;
   assign apply         = pend_q & (tick_raw | (mode_q == MODE_OFF));

   // NOTE: every always_comb output gets a default first so no path can infer a latch.
   always_comb begin
      mode_d      = mode_q;
      div_d       = div_q;
      presc_d     = presc_q;
      pat_d       = pat_q;
      pend_d      = pend_q;
      pend_mode_d = pend_mode_q;
      pend_div_d  = pend_div_q;

      if (accept) begin
         pend_d      = 1'b1;
         pend_mode_d = mode_e'(cfg.cfg_mode);
         pend_div_d  = cfg.cfg_div;
      end

      // An apply restarts the period and suppresses the pattern step of that tick.
      if (apply) begin
         pend_d  = 1'b0;
         mode_d  = pend_mode_q;
         div_d   = pend_div_q;
         presc_d = '0;
         pat_d   = init_pat(pend_mode_q);
      end else if (tick_raw) begin
         presc_d = '0;
         case (mode_q)
            MODE_OFF:   pat_d = '0;
            MODE_BLINK: pat_d = ~pat_q;
            MODE_COUNT: pat_d = pat_q + LED_W'(1);
            MODE_CHASE: pat_d = {pat_q[LED_W-2:0], pat_q[LED_W-1]};
         endcase
      end else begin
         presc_d = presc_q + PRESC_W'(1);
      end
   end

   // NOTE: state is updated with non-blocking assignments under an asynchronous active-low reset.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         mode_q      <= MODE_OFF;
         div_q       <= '0;
         presc_q     <= '0;
         pat_q       <= '0;
         pend_q      <= 1'b0;
         pend_mode_q <= MODE_OFF;
         pend_div_q  <= '0;
         pwm_q       <= '0;
      end else begin
         mode_q      <= mode_d;
         div_q       <= div_d;
         presc_q     <= presc_d;
         pat_q       <= pat_d;
         pend_q      <= pend_d;
         pend_mode_q <= pend_mode_d;
         pend_div_q  <= pend_div_d;
         pwm_q       <= pwm_q + PWM_W'(1);
      end
   end

   assign pwm_on  = (pwm_q < bright) || (bright == '1);
   assign led_raw = pat_q & {LED_W{pwm_on}};
   assign mode    = mode_q;

`ifdef LED_PATTERN_OUT_REG_EN
   logic [LED_W-1:0] led_q;
   logic             tick_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         led_q  <= '0;
         tick_q <= 1'b0;
      end else begin
         led_q  <= led_raw;
         tick_q <= tick_raw;
      end
   end

   assign LED  = led_q;
   assign tick = tick_q;
`else
   assign LED  = led_raw;
   // Prescaler sits at 0 == div_q during reset, so the raw compare is masked to keep tick low.
   assign tick = tick_raw & rst_n;
`endif

endmodule
